// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the single-ported data memory port.
// The arbiter connects through the slave modport; requesters and memory sit on the master side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MEM_AW = 10
);
  logic              p0_req;
  logic              p1_req;
  logic              p0_we;
  logic              p1_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_done;
  logic              p1_done;
  logic [DATA_W-1:0] p0_rdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              p0_err;
  logic              p1_err;
  logic              m_stall;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  mem_rdata, mem_ack,
    output p0_done, p1_done, p0_rdata, p1_rdata, p0_err, p1_err, m_stall,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output mem_rdata, mem_ack,
    input  p0_done, p1_done, p0_rdata, p1_rdata, p0_err, p1_err, m_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the pipeline (port 0) and the loader (port 1).
// One access in flight; out-of-range addresses and memory timeouts complete with err=1.
module dmem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst_n,
  dmem_arbiter_if.slave  bus
);
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic              owner;
  logic              last_grant;
  logic              lat_we;
  logic [MEM_AW-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              err0;
  logic              err1;

  logic              grant;
  logic              grant_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              load_resp;
  logic              resp_port;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic              cnt_clr;
  logic              cnt_inc;

  // On a tie port 1 wins only when port 0 was the last one served.
  always_comb begin
    grant_port = bus.p1_req & ~(bus.p0_req & last_grant);
    sel_we     = grant_port ? bus.p1_we    : bus.p0_we;
    sel_addr   = grant_port ? bus.p1_addr  : bus.p0_addr;
    sel_wdata  = grant_port ? bus.p1_wdata : bus.p0_wdata;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    load_resp  = 1'b0;
    resp_port  = owner;
    resp_err   = 1'b0;
    resp_rdata = '0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          grant     = 1'b1;
          resp_port = grant_port;
          if (sel_addr >= ADDR_W'(DEPTH)) begin
            state_next = RESP;
            load_resp  = 1'b1;
            resp_err   = 1'b1;
          end else begin
            state_next = ISSUE;
            cnt_clr    = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_ack) begin
          state_next = RESP;
          load_resp  = 1'b1;
          resp_rdata = lat_we ? '0 : bus.mem_rdata;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_next = RESP;
          load_resp  = 1'b1;
          resp_err   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        owner     <= grant_port;
        lat_we    <= sel_we;
        lat_addr  <= sel_addr[MEM_AW-1:0];
        lat_wdata <= sel_wdata;
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (load_resp) begin
        if (resp_port) begin
          rdata1 <= resp_rdata;
          err1   <= resp_err;
        end else begin
          rdata0 <= resp_rdata;
          err0   <= resp_err;
        end
      end
      if (state == RESP) begin
        last_grant <= owner;
      end
    end
  end

  // Memory fields are forced to zero outside ISSUE so the bus is quiet when idle.
  assign bus.mem_req   = (state == ISSUE);
  assign bus.mem_we    = (state == ISSUE) & lat_we;
  assign bus.mem_addr  = (state == ISSUE) ? lat_addr  : '0;
  assign bus.mem_wdata = (state == ISSUE) ? lat_wdata : '0;
  assign bus.p0_done   = (state == RESP) & ~owner;
  assign bus.p1_done   = (state == RESP) & owner;
  assign bus.p0_rdata  = rdata0;
  assign bus.p1_rdata  = rdata1;
  assign bus.p0_err    = err0;
  assign bus.p1_err    = err1;
  assign bus.m_stall   = bus.p0_req & ~bus.p0_done;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a transaction-level model.
// The bench also plays the memory, acknowledging after a programmable latency.
module tb_dmem_arbiter;
  logic clk;
  logic rst_n;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total  = 0;
  int          passed = 0;
  int          failed = 0;
  int          ack_lat = 1;
  logic        no_ack  = 1'b0;
  logic [63:0] mem_store [1024];
  logic [63:0] ref_mem   [1024];
  logic [63:0] exp_rdata [2];
  logic        exp_err   [2];
  int          last_g;

  function automatic logic [63:0] initWord(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'(i) ^ 32'h5A5A_5A5A};
  endfunction

  // Memory responder: counts mem_req cycles and acks once the latency is reached.
  initial begin
    int wait_cnt;
    wait_cnt      = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem_store[i] = initWord(i);
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        wait_cnt      = 0;
      end else if (bus.mem_req && !no_ack) begin
        wait_cnt++;
        if (wait_cnt >= ack_lat) begin
          if (bus.mem_we) mem_store[bus.mem_addr] = bus.mem_wdata;
          else            bus.mem_rdata = mem_store[bus.mem_addr];
          bus.mem_ack = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic doneOf(input int p);
    return p ? bus.p1_done : bus.p0_done;
  endfunction

  task automatic setReq(input int p, input logic req, input logic we,
                        input logic [63:0] addr, input logic [63:0] wdata);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  task automatic checkRespRegs(input string tag);
    checkOutput({tag, "_p0_rdata"}, bus.p0_rdata, exp_rdata[0]);
    checkOutput({tag, "_p0_err"},   bus.p0_err,   exp_err[0]);
    checkOutput({tag, "_p1_rdata"}, bus.p1_rdata, exp_rdata[1]);
    checkOutput({tag, "_p1_err"},   bus.p1_err,   exp_err[1]);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    setReq(0, 1'b0, 1'b0, '0, '0);
    setReq(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_g       = 1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_err[0]   = 1'b0; exp_err[1] = 1'b0;
  endtask

  // One access from a single port, checked cycle by cycle until its done pulse.
  task automatic applyStimulus(input int p, input logic we, input logic [63:0] addr,
                               input logic [63:0] wdata, input int lat, input logic noack);
    logic        oor;
    int          issue_len;
    logic [9:0]  idx;
    oor       = (addr >= 64'd1024);
    issue_len = oor ? 0 : (noack ? 15 : lat);
    idx       = addr[9:0];
    ack_lat   = lat;
    no_ack    = noack;
    @(negedge clk);
    setReq(p, 1'b1, we, addr, wdata);
    #1;
    if (p == 0) checkOutput("stall_on_req", bus.m_stall, 1'b1);
    for (int c = 1; c <= issue_len + 1; c++) begin
      @(negedge clk);
      checkOutput("mem_req", bus.mem_req, c <= issue_len);
      checkOutput("done", doneOf(p), c == issue_len + 1);
      checkOutput("other_done", doneOf(1 - p), 1'b0);
      if (c == 1 && issue_len > 0) begin
        checkOutput("mem_we", bus.mem_we, we);
        checkOutput("mem_addr", bus.mem_addr, idx);
        if (we) checkOutput("mem_wdata", bus.mem_wdata, wdata);
      end
      if (p == 0) checkOutput("m_stall", bus.m_stall, c <= issue_len);
    end
    if (oor || noack) begin
      exp_rdata[p] = '0;
      exp_err[p]   = 1'b1;
    end else begin
      if (we) begin
        ref_mem[idx] = wdata;
        exp_rdata[p] = '0;
      end else begin
        exp_rdata[p] = ref_mem[idx];
      end
      exp_err[p] = 1'b0;
    end
    checkRespRegs("resp");
    last_g = p;
    setReq(p, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("done_pulse", doneOf(p), 1'b0);
    checkOutput("idle_mem_req", bus.mem_req, 1'b0);
    no_ack = 1'b0;
  endtask

  // Both ports request continuously; grants must alternate with 3-cycle spacing.
  task automatic contend(input logic [63:0] a0, input logic [63:0] a1, input logic we1,
                         input logic [63:0] wd1, input int n);
    int got;
    int last_c;
    int exp_p;
    got     = 0;
    last_c  = 0;
    ack_lat = 1;
    @(negedge clk);
    setReq(0, 1'b1, 1'b0, a0, '0);
    setReq(1, 1'b1, we1, a1, wd1);
    for (int c = 1; c <= 4 * n + 10 && got < n; c++) begin
      @(negedge clk);
      if (bus.p0_done || bus.p1_done) begin
        exp_p = 1 - last_g;
        checkOutput("rr_p0_done", bus.p0_done, exp_p == 0);
        checkOutput("rr_p1_done", bus.p1_done, exp_p == 1);
        if (exp_p == 0) begin
          exp_rdata[0] = ref_mem[a0[9:0]];
        end else if (we1) begin
          ref_mem[a1[9:0]] = wd1;
          exp_rdata[1]     = '0;
        end else begin
          exp_rdata[1] = ref_mem[a1[9:0]];
        end
        exp_err[exp_p] = 1'b0;
        checkRespRegs("rr");
        if (got > 0) checkOutput("rr_spacing", c - last_c, 3);
        last_c = c;
        last_g = exp_p;
        got++;
        if (got == n) begin
          setReq(0, 1'b0, 1'b0, '0, '0);
          setReq(1, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    checkOutput("rr_count", got, n);
    setReq(0, 1'b0, 1'b0, '0, '0);
    setReq(1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [63:0] ra;
    int          sel;
    for (int i = 0; i < 1024; i++) ref_mem[i] = initWord(i);
    rst_n = 1'b0;
    setReq(0, 1'b0, 1'b0, '0, '0);
    setReq(1, 1'b0, 1'b0, '0, '0);
    last_g       = 1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_err[0]   = 1'b0; exp_err[1] = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_req", bus.mem_req, 1'b0);
    checkOutput("rst_p0_done", bus.p0_done, 1'b0);
    checkOutput("rst_p1_done", bus.p1_done, 1'b0);
    checkOutput("rst_m_stall", bus.m_stall, 1'b0);
    checkRespRegs("rst");
    rst_n = 1'b1;

    $display("[TB] directed write/read");
    applyStimulus(0, 1'b1, 64'd5, 64'hDEAD, 1, 1'b0);
    applyStimulus(0, 1'b0, 64'd5, '0, 3, 1'b0);

    $display("[TB] round-robin from reset");
    doReset();
    contend(64'd1, 64'd2, 1'b1, 64'd7, 2);
    contend(64'd2, 64'd1, 1'b0, '0, 6);

    $display("[TB] out-of-range and timeout");
    applyStimulus(1, 1'b0, 64'd1024, '0, 1, 1'b0);
    applyStimulus(0, 1'b1, 64'hFFFF_0000_0000_0005, 64'h1111, 1, 1'b0);
    applyStimulus(1, 1'b1, 64'd1023, 64'hCAFE_F00D, 2, 1'b0);
    applyStimulus(0, 1'b0, 64'd1023, '0, 1, 1'b0);
    applyStimulus(0, 1'b0, 64'd3, '0, 1, 1'b1);
    applyStimulus(0, 1'b0, 64'd3, '0, 1, 1'b0);

    $display("[TB] randomized accesses");
    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      ra = {$urandom, $urandom} | 64'd1024;
      else if (sel == 1) ra = 64'd1023;
      else               ra = 64'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 1), 1'($urandom_range(0, 1)), ra,
                    {$urandom, $urandom}, $urandom_range(1, 4), 1'b0);
    end

    $display("[TB] reset during ISSUE");
    applyStimulus(1, 1'b1, 64'd9, 64'h1234, 1, 1'b0);
    applyStimulus(0, 1'b0, 64'd9, '0, 1, 1'b0);
    no_ack = 1'b1;
    @(negedge clk);
    setReq(0, 1'b1, 1'b1, 64'd7, 64'hBEEF);
    repeat (3) @(negedge clk);
    checkOutput("mid_issue_mem_req", bus.mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_mem_req", bus.mem_req, 1'b0);
    checkOutput("async_mem_we", bus.mem_we, 1'b0);
    checkOutput("async_mem_addr", bus.mem_addr, '0);
    checkOutput("async_p0_done", bus.p0_done, 1'b0);
    checkOutput("async_p0_err", bus.p0_err, 1'b0);
    checkOutput("async_p0_rdata", bus.p0_rdata, '0);
    checkOutput("async_p1_rdata", bus.p1_rdata, '0);
    setReq(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n  = 1'b1;
    no_ack = 1'b0;
    last_g       = 1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_err[0]   = 1'b0; exp_err[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("post_rst_done", bus.p0_done | bus.p1_done, 1'b0);
      checkOutput("post_rst_mem_req", bus.mem_req, 1'b0);
    end
    applyStimulus(0, 1'b0, 64'd7, '0, 2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
